// File: rtl/cpu_axi_master.sv
// Core request port to single-beat AXI3 master; one transaction in flight at a time.
// Write path present only when CPU_AXI_MASTER_WRITE_EN is defined; otherwise writes complete with an error.
module cpu_axi_master #(
   parameter int         ADDR_W = 32,
   parameter int         DATA_W = 32,
   parameter logic [3:0] AXI_ID = 4'd0
) (
   input  logic                aclk_i,
   input  logic                aresetn_i,
   input  logic                cpu_req_i,
   input  logic                cpu_we_i,
   input  logic [ADDR_W-1:0]   cpu_addr_i,
   input  logic [DATA_W-1:0]   cpu_wdata_i,
   input  logic [DATA_W/8-1:0] cpu_wstrb_i,
   output logic                cpu_gnt_o,
   output logic                cpu_rvalid_o,
   output logic [DATA_W-1:0]   cpu_rdata_o,
   output logic                cpu_wdone_o,
   output logic                cpu_err_o,
   output logic [ADDR_W-1:0]   m_araddr_o,
   output logic                m_arvalid_o,
   output logic [3:0]          m_arid_o,
   output logic [3:0]          m_arlen_o,
   output logic [2:0]          m_arsize_o,
   output logic [1:0]          m_arburst_o,
   output logic [1:0]          m_arlock_o,
   output logic [3:0]          m_arcache_o,
   output logic [2:0]          m_arprot_o,
   input  logic                m_arready_i,
   input  logic [DATA_W-1:0]   m_rdata_i,
   input  logic [1:0]          m_rresp_i,
   input  logic                m_rvalid_i,
   input  logic                m_rlast_i,
   input  logic [3:0]          m_rid_i,
   output logic                m_rready_o,
   output logic [ADDR_W-1:0]   m_awaddr_o,
   output logic                m_awvalid_o,
   output logic [3:0]          m_awid_o,
   output logic [3:0]          m_awlen_o,
   output logic [2:0]          m_awsize_o,
   output logic [1:0]          m_awburst_o,
   output logic [1:0]          m_awlock_o,
   output logic [3:0]          m_awcache_o,
   output logic [2:0]          m_awprot_o,
   input  logic                m_awready_i,
   output logic [DATA_W-1:0]   m_wdata_o,
   output logic [DATA_W/8-1:0] m_wstrb_o,
   output logic                m_wvalid_o,
   output logic [3:0]          m_wid_o,
   output logic                m_wlast_o,
   input  logic                m_wready_i,
   input  logic                m_bvalid_i,
   input  logic [1:0]          m_bresp_i,
   input  logic [3:0]          m_bid_i,
   output logic                m_bready_o
);

   localparam int         STRB_W = DATA_W / 8;
   localparam logic [2:0] SIZE   = 3'($clog2(STRB_W));

   typedef enum logic [2:0] {IDLE, AR, R, WR, B} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                rvalid_q, rvalid_d;
   logic                wdone_q, wdone_d;
   logic                err_q, err_d;
   logic                aw_done_q, aw_done_d;
   logic                w_done_q, w_done_d;
   logic                gnt;

   // Gated by reset so the grant is low while reset is held.
   assign gnt = cpu_req_i & (state_q == IDLE) & aresetn_i;

   always_ff @(posedge aclk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         we_q      <= 1'b0;
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
         wdone_q   <= 1'b0;
         err_q     <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         we_q      <= we_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
         wdone_q   <= wdone_d;
         err_q     <= err_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      we_d      = we_q;
      rdata_d   = rdata_q;
      rvalid_d  = 1'b0;
      wdone_d   = 1'b0;
      err_d     = 1'b0;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      case (state_q)
         IDLE: if (gnt) begin
            addr_d  = cpu_addr_i;
            wdata_d = cpu_wdata_i;
            wstrb_d = cpu_wstrb_i;
            we_d    = cpu_we_i;
`ifdef CPU_AXI_MASTER_WRITE_EN
            state_d = cpu_we_i ? WR : AR;
`else
            // No write path: report the write as failed without touching the bus.
            if (cpu_we_i) begin
               wdone_d = 1'b1;
               err_d   = 1'b1;
            end else begin
               state_d = AR;
            end
`endif
         end
         AR: if (m_arready_i) state_d = R;
         R: if (m_rvalid_i) begin
            rdata_d  = m_rdata_i;
            rvalid_d = 1'b1;
            err_d    = (m_rresp_i != 2'b00) | ~m_rlast_i;
            state_d  = IDLE;
         end
`ifdef CPU_AXI_MASTER_WRITE_EN
         WR: begin
            aw_done_d = aw_done_q | m_awready_i;
            w_done_d  = w_done_q | m_wready_i;
            if (aw_done_d && w_done_d) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = B;
            end
         end
         B: if (m_bvalid_i) begin
            wdone_d = 1'b1;
            err_d   = (m_bresp_i != 2'b00);
            state_d = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   assign cpu_gnt_o    = gnt;
   assign cpu_rvalid_o = rvalid_q;
   assign cpu_rdata_o  = rdata_q;
   assign cpu_wdone_o  = wdone_q;
   assign cpu_err_o    = err_q;

   assign m_araddr_o  = addr_q;
   assign m_arvalid_o = (state_q == AR);
   assign m_arid_o    = AXI_ID;
   assign m_arlen_o   = 4'd0;
   assign m_arsize_o  = SIZE;
   assign m_arburst_o = 2'b01;
   assign m_arlock_o  = 2'b00;
   assign m_arcache_o = 4'd0;
   assign m_arprot_o  = 3'd0;
   assign m_rready_o  = (state_q == R);

   assign m_awaddr_o  = addr_q;
   assign m_awid_o    = AXI_ID;
   assign m_awlen_o   = 4'd0;
   assign m_awsize_o  = SIZE;
   assign m_awburst_o = 2'b01;
   assign m_awlock_o  = 2'b00;
   assign m_awcache_o = 4'd0;
   assign m_awprot_o  = 3'd0;
   assign m_wdata_o   = wdata_q;
   assign m_wstrb_o   = wstrb_q;
   assign m_wid_o     = AXI_ID;
   assign m_wlast_o   = 1'b1;

`ifdef CPU_AXI_MASTER_WRITE_EN
   assign m_awvalid_o = (state_q == WR) & ~aw_done_q;
   assign m_wvalid_o  = (state_q == WR) & ~w_done_q;
   assign m_bready_o  = (state_q == B);
   logic unused_sig;
   assign unused_sig = ^{m_rid_i, m_bid_i, we_q};
`else
   assign m_awvalid_o = 1'b0;
   assign m_wvalid_o  = 1'b0;
   assign m_bready_o  = 1'b0;
   logic unused_sig;
   assign unused_sig = ^{m_rid_i, m_bid_i, we_q, m_awready_i, m_wready_i,
                         m_bvalid_i, m_bresp_i, aw_done_q, w_done_q};
`endif

endmodule

// File: tb/tb_cpu_axi_master.sv
// Directed bench for cpu_axi_master: read path, stalls, errors, reset, and write behaviour for the active build.
module tb_cpu_axi_master;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata;
   logic [3:0]  cpu_wstrb;
   logic        cpu_gnt, cpu_rvalid, cpu_wdone, cpu_err;
   logic [31:0] cpu_rdata;
   logic [31:0] m_araddr, m_awaddr, m_rdata, m_wdata;
   logic        m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
   logic        m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
   logic [3:0]  m_arid, m_awid, m_wid, m_rid, m_bid, m_arlen, m_awlen, m_arcache, m_awcache, m_wstrb;
   logic [2:0]  m_arsize, m_awsize, m_arprot, m_awprot;
   logic [1:0]  m_arburst, m_awburst, m_arlock, m_awlock, m_rresp, m_bresp;

   int checks = 0;
   int errors = 0;

   always #5 aclk = ~aclk;

   cpu_axi_master dut (
      .aclk_i(aclk), .aresetn_i(aresetn),
      .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
      .cpu_wdata_i(cpu_wdata), .cpu_wstrb_i(cpu_wstrb),
      .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
      .cpu_wdone_o(cpu_wdone), .cpu_err_o(cpu_err),
      .m_araddr_o(m_araddr), .m_arvalid_o(m_arvalid), .m_arid_o(m_arid),
      .m_arlen_o(m_arlen), .m_arsize_o(m_arsize), .m_arburst_o(m_arburst),
      .m_arlock_o(m_arlock), .m_arcache_o(m_arcache), .m_arprot_o(m_arprot),
      .m_arready_i(m_arready), .m_rdata_i(m_rdata), .m_rresp_i(m_rresp),
      .m_rvalid_i(m_rvalid), .m_rlast_i(m_rlast), .m_rid_i(m_rid), .m_rready_o(m_rready),
      .m_awaddr_o(m_awaddr), .m_awvalid_o(m_awvalid), .m_awid_o(m_awid),
      .m_awlen_o(m_awlen), .m_awsize_o(m_awsize), .m_awburst_o(m_awburst),
      .m_awlock_o(m_awlock), .m_awcache_o(m_awcache), .m_awprot_o(m_awprot),
      .m_awready_i(m_awready), .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb),
      .m_wvalid_o(m_wvalid), .m_wid_o(m_wid), .m_wlast_o(m_wlast),
      .m_wready_i(m_wready), .m_bvalid_i(m_bvalid), .m_bresp_i(m_bresp),
      .m_bid_i(m_bid), .m_bready_o(m_bready)
   );

   // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic idle_inputs();
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_wstrb = 0;
      m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0; m_rid = 0;
      m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0; m_bid = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      aresetn = 0;
      @(posedge aclk); @(negedge aclk);
      checks++; if ({cpu_gnt, cpu_rvalid, cpu_wdone, cpu_err} !== 4'b0) begin errors++; $display("FAIL rst_cpu_flags: got %b want 0000", {cpu_gnt, cpu_rvalid, cpu_wdone, cpu_err}); end
      checks++; if ({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready} !== 5'b0) begin errors++; $display("FAIL rst_bus_flags: got %b want 00000", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}); end
      checks++; if (cpu_rdata !== 32'h0 || m_araddr !== 32'h0) begin errors++; $display("FAIL rst_regs: rdata %h araddr %h want 0", cpu_rdata, m_araddr); end
      checks++; if ({m_arlen, m_arsize, m_arburst, m_wlast} !== {4'd0, 3'd2, 2'b01, 1'b1}) begin errors++; $display("FAIL ar_consts: len %h size %h burst %b wlast %b", m_arlen, m_arsize, m_arburst, m_wlast); end
      tick();
      aresetn = 1;
   endtask

   task automatic test_read();
      tick();  // c0
      cpu_req = 1; cpu_addr = 32'h100;
      m_arready = 1; m_rvalid = 1; m_rdata = 32'hDEADBEEF; m_rresp = 0; m_rlast = 1;
      @(negedge aclk);
      checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b want 1", cpu_gnt); end
      tick();  // c1
      cpu_req = 0;
      @(negedge aclk);
      checks++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h100) begin errors++; $display("FAIL rd_ar: arvalid %b araddr %h want 1/100", m_arvalid, m_araddr); end
      checks++; if (m_rready !== 1'b0) begin errors++; $display("FAIL rd_rready_in_ar: got %b want 0", m_rready); end
      tick();  // c2
      @(negedge aclk);
      checks++; if (m_rready !== 1'b1 || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rd_r: rready %b rvalid %b want 1/0", m_rready, cpu_rvalid); end
      tick();  // c3
      idle_inputs();
      @(negedge aclk);
      checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || cpu_err !== 1'b0) begin errors++; $display("FAIL rd_done: rvalid %b rdata %h err %b want 1/deadbeef/0", cpu_rvalid, cpu_rdata, cpu_err); end
      tick();  // c4
      @(negedge aclk);
      checks++; if (cpu_rvalid !== 1'b0 || m_arvalid !== 1'b0) begin errors++; $display("FAIL rd_pulse: rvalid %b arvalid %b want 0/0", cpu_rvalid, m_arvalid); end
   endtask

   task automatic test_ar_stall();
      tick();  // c0
      cpu_req = 1; cpu_addr = 32'h200;
      @(negedge aclk);
      checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL st_gnt: got %b want 1", cpu_gnt); end
      tick();  // c1
      cpu_req = 0;
      for (int k = 1; k <= 5; k++) begin
         if (k > 1) tick();
         if (k == 2) begin cpu_req = 1; cpu_addr = 32'h300; end
         @(negedge aclk);
         checks++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h200) begin errors++; $display("FAIL st_hold c%0d: arvalid %b araddr %h want 1/200", k, m_arvalid, m_araddr); end
         if (k >= 2) begin
            checks++; if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL st_nogrant c%0d: got %b want 0", k, cpu_gnt); end
         end
      end
      tick();  // c6
      m_arready = 1;
      @(negedge aclk);
      checks++; if (m_arvalid !== 1'b1 || cpu_gnt !== 1'b0) begin errors++; $display("FAIL st_ar_hs: arvalid %b gnt %b want 1/0", m_arvalid, cpu_gnt); end
      tick();  // c7
      m_arready = 0; m_rvalid = 1; m_rdata = 32'hCAFEF00D; m_rlast = 1;
      @(negedge aclk);
      checks++; if (m_rready !== 1'b1) begin errors++; $display("FAIL st_rready: got %b want 1", m_rready); end
      tick();  // c8: completion, held request granted in the same cycle
      m_rvalid = 0;
      @(negedge aclk);
      checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hCAFEF00D || cpu_err !== 1'b0) begin errors++; $display("FAIL st_done: rvalid %b rdata %h err %b want 1/cafef00d/0", cpu_rvalid, cpu_rdata, cpu_err); end
      checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt: got %b want 1", cpu_gnt); end
      tick();  // c9
      cpu_req = 0; m_arready = 1;
      @(negedge aclk);
      checks++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h300) begin errors++; $display("FAIL b2b_ar: arvalid %b araddr %h want 1/300", m_arvalid, m_araddr); end
      tick();  // c10: OKAY response but rlast low
      m_arready = 0; m_rvalid = 1; m_rdata = 32'h11112222; m_rresp = 0; m_rlast = 0;
      tick();  // c11
      m_rvalid = 0;
      @(negedge aclk);
      checks++; if (cpu_rvalid !== 1'b1 || cpu_err !== 1'b1 || cpu_rdata !== 32'h11112222) begin errors++; $display("FAIL rlast_err: rvalid %b err %b rdata %h want 1/1/11112222", cpu_rvalid, cpu_err, cpu_rdata); end
      tick();  // c12
      @(negedge aclk);
      checks++; if (cpu_rvalid !== 1'b0 || cpu_err !== 1'b0 || cpu_rdata !== 32'h11112222) begin errors++; $display("FAIL rdata_hold: rvalid %b err %b rdata %h want 0/0/11112222", cpu_rvalid, cpu_err, cpu_rdata); end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      tick();  // c0
      cpu_req = 1; cpu_addr = 32'h500; m_arready = 1;
      tick();  // c1
      cpu_req = 0;
      tick();  // c2: in R, slave withholds rvalid
      m_arready = 0;
      @(negedge aclk);
      checks++; if (m_rready !== 1'b1) begin errors++; $display("FAIL rm_in_r: rready %b want 1", m_rready); end
      #1 aresetn = 0;
      #1;
      checks++; if (m_rready !== 1'b0 || m_arvalid !== 1'b0 || cpu_rdata !== 32'h0) begin errors++; $display("FAIL rm_async: rready %b arvalid %b rdata %h want 0/0/0", m_rready, m_arvalid, cpu_rdata); end
      tick();
      aresetn = 1;
      tick();  // c0 of fresh read
      cpu_req = 1; cpu_addr = 32'h600;
      m_arready = 1; m_rvalid = 1; m_rdata = 32'h5A5A5A5A; m_rresp = 0; m_rlast = 1;
      @(negedge aclk);
      checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL rm_gnt: got %b want 1", cpu_gnt); end
      tick(); cpu_req = 0;
      tick();
      tick();  // c3
      idle_inputs();
      @(negedge aclk);
      checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h5A5A5A5A || cpu_err !== 1'b0) begin errors++; $display("FAIL rm_read: rvalid %b rdata %h err %b want 1/5a5a5a5a/0", cpu_rvalid, cpu_rdata, cpu_err); end
   endtask

`ifdef CPU_AXI_MASTER_WRITE_EN
   task automatic test_write();
      tick();  // c0: AW ready at once, W ready three cycles late
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h400; cpu_wdata = 32'h12345678; cpu_wstrb = 4'hF;
      m_awready = 1; m_wready = 0;
      @(negedge aclk);
      checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b want 1", cpu_gnt); end
      tick();  // c1
      idle_inputs(); m_awready = 1;
      @(negedge aclk);
      checks++; if ({m_awvalid, m_wvalid, m_bready} !== 3'b110 || m_wdata !== 32'h12345678 || m_wstrb !== 4'hF || m_awaddr !== 32'h400) begin errors++; $display("FAIL wr_c1: aw/w/b %b wdata %h wstrb %h awaddr %h", {m_awvalid, m_wvalid, m_bready}, m_wdata, m_wstrb, m_awaddr); end
      for (int k = 2; k <= 4; k++) begin
         tick();
         if (k == 4) m_wready = 1;
         @(negedge aclk);
         checks++; if ({m_awvalid, m_wvalid, m_bready} !== 3'b010 || m_wdata !== 32'h12345678) begin errors++; $display("FAIL wr_wait c%0d: aw/w/b %b wdata %h want 010/12345678", k, {m_awvalid, m_wvalid, m_bready}, m_wdata); end
      end
      tick();  // c5
      m_wready = 0; m_awready = 0; m_bvalid = 1; m_bresp = 0;
      @(negedge aclk);
      checks++; if ({m_awvalid, m_wvalid, m_bready} !== 3'b001) begin errors++; $display("FAIL wr_b: aw/w/b %b want 001", {m_awvalid, m_wvalid, m_bready}); end
      tick();  // c6
      m_bvalid = 0;
      @(negedge aclk);
      checks++; if (cpu_wdone !== 1'b1 || cpu_err !== 1'b0 || m_bready !== 1'b0) begin errors++; $display("FAIL wr_done: wdone %b err %b bready %b want 1/0/0", cpu_wdone, cpu_err, m_bready); end
   endtask

   task automatic test_write_err();
      tick();  // c0
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h404; cpu_wdata = 32'hA5A5A5A5; cpu_wstrb = 4'h3;
      m_awready = 1; m_wready = 1;
      tick();  // c1: AW+W handshake
      cpu_req = 0; cpu_we = 0;
      tick();  // c2: B
      m_awready = 0; m_wready = 0; m_bvalid = 1; m_bresp = 2'b10;
      tick();  // c3
      idle_inputs();
      @(negedge aclk);
      checks++; if (cpu_wdone !== 1'b1 || cpu_err !== 1'b1) begin errors++; $display("FAIL wr_slverr: wdone %b err %b want 1/1", cpu_wdone, cpu_err); end
   endtask
`else
   task automatic test_write();
      tick();  // c0
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h400; cpu_wdata = 32'h12345678; cpu_wstrb = 4'hF;
      m_awready = 1; m_wready = 1;
      @(negedge aclk);
      checks++; if (cpu_gnt !== 1'b1 || m_awvalid !== 1'b0) begin errors++; $display("FAIL nw_gnt: gnt %b awvalid %b want 1/0", cpu_gnt, m_awvalid); end
      tick();  // c1
      idle_inputs();
      @(negedge aclk);
      checks++; if (cpu_wdone !== 1'b1 || cpu_err !== 1'b1) begin errors++; $display("FAIL nw_done: wdone %b err %b want 1/1", cpu_wdone, cpu_err); end
      checks++; if ({m_awvalid, m_wvalid, m_bready, m_arvalid} !== 4'b0) begin errors++; $display("FAIL nw_nobus: aw/w/b/ar %b want 0000", {m_awvalid, m_wvalid, m_bready, m_arvalid}); end
      tick();  // c2
      @(negedge aclk);
      checks++; if (cpu_wdone !== 1'b0 || cpu_err !== 1'b0 || m_awvalid !== 1'b0) begin errors++; $display("FAIL nw_pulse: wdone %b err %b awvalid %b want 0/0/0", cpu_wdone, cpu_err, m_awvalid); end
   endtask

   task automatic test_write_err();
      tick();
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h404;
      tick();
      idle_inputs();
      @(negedge aclk);
      checks++; if (cpu_wdone !== 1'b1 || cpu_err !== 1'b1 || m_awvalid !== 1'b0) begin errors++; $display("FAIL nw_again: wdone %b err %b awvalid %b want 1/1/0", cpu_wdone, cpu_err, m_awvalid); end
   endtask
`endif

   initial begin
      test_reset();
      test_read();
      test_ar_stall();
      test_reset_mid();
      test_write();
      test_write_err();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_axi_master.md
# cpu_axi_master

- Upstream neighbour of the AXI-to-SRAM bridge.
- Converts the core's single-outstanding request interface (cpu_*) into single-beat AXI3 transactions on the m_* master port.
- Serialises reads and writes through one FSM: at most one transaction in flight.
- Returns read data, write completion and error status to the core as one-cycle pulses.

## Interface
Parameters:
- ADDR_W, 32, address width (cpu_addr, m_araddr, m_awaddr)
- DATA_W, 32, data width; strobe width DATA_W/8
- AXI_ID, 0, constant driven on m_arid/m_awid/m_wid (4 bits)

Ports:
- aclk  in  1  clock, all logic rising-edge
- aresetn  in  1  reset, asynchronous assert, active-low
- cpu_req  in  1  request valid
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  DATA_W  write data
- cpu_wstrb  in  DATA_W/8  byte enables
- cpu_gnt  out  1  request accepted this cycle
- cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid
- cpu_rdata  out  DATA_W  read data
- cpu_wdone  out  1  one-cycle pulse, write completed
- cpu_err  out  1  qualifies cpu_rvalid/cpu_wdone, non-OKAY response
- m_ar*  out  araddr, arvalid, arid; arlen=0, arsize=log2(DATA_W/8), arburst=01, arlock/arcache/arprot=0
- m_arready  in  1
- m_rdata/m_rresp/m_rvalid/m_rlast/m_rid  in
- m_rready  out  1
- m_aw*  out  awaddr, awvalid, awid; constants as AR
- m_awready  in  1
- m_wdata/m_wstrb/m_wvalid/m_wid  out
- m_wlast  out  1  tied 1
- m_wready  in  1
- m_bvalid/m_bresp/m_bid  in
- m_bready  out  1

## Operation
- States: IDLE, AR, R, WR, B.
- cpu_gnt = cpu_req & (state==IDLE).
- On grant: latch cpu_addr/cpu_wdata/cpu_wstrb/cpu_we into registers. Go to WR if cpu_we, else AR.
- AR:
  - m_arvalid=1, address from latch.
  - On m_arready: go to R.
  - m_rready=0 in AR. The downstream bridge requires rready low in the AR handshake cycle.
- R:
  - m_rready=1.
  - On m_rvalid: register m_rdata into cpu_rdata.
  - Next cycle: pulse cpu_rvalid; cpu_err = (m_rresp!=0) | ~m_rlast.
  - Go to IDLE.
- WR:
  - m_awvalid and m_wvalid asserted together.
  - aw_done/w_done flags; each valid drops after its own handshake.
  - Both done (same or different cycles): go to B.
- B:
  - m_bready=1.
  - On m_bvalid: next cycle pulse cpu_wdone; cpu_err = (m_bresp!=0). Go to IDLE.
- Flow control:
  - cpu_req while not IDLE is ignored (cpu_gnt=0). The core holds it.
  - cpu_rdata holds its last value until the next read completes.
  - m_rid/m_bid are ignored.
- Valids never drop before their handshake. Address and data stay stable while valid.

## Timing
- Reset values:
  - State IDLE.
  - All m_*valid, m_rready, m_bready, cpu_gnt, cpu_rvalid, cpu_wdone, cpu_err = 0.
  - cpu_rdata = 0; latches = 0.
- Reset mid-transaction: immediately IDLE, all outputs to reset values, in-flight transaction dropped.
- Read latency against the zero-wait bridge:
  - grant c0
  - AR handshake c1
  - R handshake c2
  - cpu_rvalid c3
  - next grant possible c3 (IDLE in c3)
- Write latency with AW/W ready immediately:
  - grant c0
  - AW+W c1
  - B c2 (if bvalid immediate)
  - cpu_wdone c3
- Back-to-back: a new request may be granted in the same cycle cpu_rvalid/cpu_wdone pulses.

## Configuration
- CPU_AXI_MASTER_WRITE_EN defined: full write path (WR, B states) as above.
- Undefined:
  - WR/B states absent; m_awvalid, m_wvalid, m_bready tied 0.
  - A granted write completes without bus activity: cpu_wdone=1 and cpu_err=1 one cycle after grant.
  - Reads unchanged.

## Test plan
- Read, zero-wait slave returning 0xDEADBEEF/OKAY:
  - cpu_req at c0, addr 0x100 -> cpu_gnt c0, m_arvalid c1 with m_araddr=0x100, m_rready=0 in c1, cpu_rvalid c3, cpu_rdata=0xDEADBEEF, cpu_err=0.
- m_arready held low 5 cycles:
  - m_arvalid and m_araddr stable throughout.
  - cpu_req at a different address during stall -> no cpu_gnt.
  - Completion 2 cycles after arready.
- Write 0x12345678, wstrb 0xF; m_wready 3 cycles late, m_awready immediate:
  - m_awvalid drops after c1, m_wvalid stays until accepted.
  - m_bready only after both done; cpu_wdone one cycle after bvalid.
- Errors:
  - m_bresp=2'b10 -> cpu_wdone with cpu_err=1.
  - m_rresp=0 with m_rlast=0 -> cpu_rvalid with cpu_err=1.
- aresetn pulsed low while in R state -> outputs 0 asynchronously; next read after release completes normally.
- Macro undefined: write request -> cpu_wdone=1, cpu_err=1 at c1; no m_awvalid ever asserted.
